// File: rtl/exe_cmd_queue.sv
// rtl/exe_cmd_queue.sv - first-word fall-through command queue feeding the execution unit
module exe_cmd_queue #(
  parameter int m     = 4,
  parameter int n     = 2,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rsn,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [n-1:0]             i_oper,
  input  logic [m-1:0]             i_argA,
  input  logic [m-1:0]             i_argB,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [n-1:0]             o_oper,
  output logic [m-1:0]             o_argA,
  output logic [m-1:0]             o_argB,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = n + 2 * m;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign o_full     = (count == CW'(DEPTH));
  assign o_empty    = (count == '0);
  assign o_ready    = !o_full;
  assign o_valid    = !o_empty;
  assign o_count    = count;
  assign o_overflow = overflow;

  assign push = i_valid && o_ready;
  assign pop  = o_valid && i_ready;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rsn) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (i_valid && o_full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rsn && push) mem[wptr] <= {i_oper, i_argA, i_argB};
  end

  assign head = o_empty ? '0 : mem[rptr];
  assign {o_oper, o_argA, o_argB} = head;

endmodule

// File: tb/tb_exe_cmd_queue.sv
// tb/tb_exe_cmd_queue.sv - scoreboard bench for exe_cmd_queue (m=4, n=2, DEPTH=4)
module tb_exe_cmd_queue;
  localparam int M = 4;
  localparam int N = 2;
  localparam int D = 4;
  typedef logic [N+2*M-1:0] cmd_t;

  logic         i_clk = 1'b0;
  logic         i_rsn, i_valid, i_ready;
  logic [N-1:0] i_oper;
  logic [M-1:0] i_argA, i_argB;
  logic         o_ready, o_valid, o_full, o_empty, o_overflow;
  logic [N-1:0] o_oper;
  logic [M-1:0] o_argA, o_argB;
  logic [2:0]   o_count;

  cmd_t sb[$];
  int   mcnt;
  bit   movf;
  int   total;
  int   bad;

  always #5 i_clk = ~i_clk;

  exe_cmd_queue #(.m(M), .n(N), .DEPTH(D)) dut (
    .i_clk(i_clk), .i_rsn(i_rsn), .i_valid(i_valid), .o_ready(o_ready),
    .i_oper(i_oper), .i_argA(i_argA), .i_argB(i_argB),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_oper(o_oper), .o_argA(o_argA), .o_argB(o_argB),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_overflow(o_overflow)
  );

  // One clock of stimulus; the model decides acceptance from its pre-edge count.
  task automatic step(input bit v, input cmd_t c, input bit r);
    cmd_t exp;
    cmd_t got;
    bit   acc;
    bit   rem;
    i_valid = v;
    {i_oper, i_argA, i_argB} = c;
    i_ready = r;
    acc = v && (mcnt < D);
    rem = r && (mcnt > 0);
    got = {o_oper, o_argA, o_argB};
    if (rem) begin
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL head_order: got %h expected %h", got, exp);
      end
    end
    if (acc) sb.push_back(c);
    if (v && mcnt == D) movf = 1'b1;
    mcnt = mcnt + (acc ? 1 : 0) - (rem ? 1 : 0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    total++;
    if (o_count !== 3'(mcnt)) begin
      bad++;
      $display("FAIL count: got %0d expected %0d", o_count, mcnt);
    end
    total++;
    if (o_overflow !== movf) begin
      bad++;
      $display("FAIL overflow: got %b expected %b", o_overflow, movf);
    end
  endtask

  task automatic do_reset(input bit v, input cmd_t c);
    i_rsn = 1'b1;
    i_valid = v;
    i_ready = 1'b1;
    {i_oper, i_argA, i_argB} = c;
    @(posedge i_clk); #1;
    i_rsn = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    sb.delete();
    mcnt = 0;
    movf = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    total++;
    if ({o_count, o_empty, o_full, o_ready, o_valid, o_overflow} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL %s_flags: got cnt=%0d e=%b f=%b rdy=%b v=%b ovf=%b expected cnt=0 e=1 f=0 rdy=1 v=0 ovf=0",
               tag, o_count, o_empty, o_full, o_ready, o_valid, o_overflow);
    end
    total++;
    if ({o_oper, o_argA, o_argB} !== '0) begin
      bad++;
      $display("FAIL %s_head_zero: got %h expected 0", tag, {o_oper, o_argA, o_argB});
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1, 10'h3ff);
    do_reset(1'b0, '0);
    check_idle("reset");
  endtask

  task automatic test_first_push();
    cmd_t c;
    c = {2'b01, 4'b1011, 4'b0001};
    step(1'b1, c, 1'b0);
    total++;
    if (o_valid !== 1'b1 || {o_oper, o_argA, o_argB} !== c) begin
      bad++;
      $display("FAIL first_push: got v=%b head=%h expected v=1 head=%h", o_valid, {o_oper, o_argA, o_argB}, c);
    end
    step(1'b0, '0, 1'b1);
    check_idle("first_drain");
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < D; i++) step(1'b1, cmd_t'(10'h2a0 + i * 10'h041), 1'b0);
    total++;
    if (o_full !== 1'b1 || o_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_flags: got f=%b rdy=%b expected f=1 rdy=0", o_full, o_ready);
    end
    step(1'b1, 10'h155, 1'b0);
    for (int i = 0; i < D; i++) step(1'b0, '0, 1'b1);
    total++;
    if (o_empty !== 1'b1 || {o_oper, o_argA, o_argB} !== '0) begin
      bad++;
      $display("FAIL drained: got e=%b head=%h expected e=1 head=0", o_empty, {o_oper, o_argA, o_argB});
    end
  endtask

  task automatic test_simultaneous();
    do_reset(1'b0, '0);
    step(1'b1, 10'h0f3, 1'b0);
    step(1'b1, 10'h21c, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, cmd_t'($urandom), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    check_idle("simul_drain");
  endtask

  task automatic test_back_to_back();
    step(1'b1, cmd_t'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, cmd_t'($urandom), 1'b1);
    step(1'b0, '0, 1'b1);
    check_idle("stream_drain");
  endtask

  task automatic test_full_push_pop();
    do_reset(1'b0, '0);
    for (int i = 0; i < D; i++) step(1'b1, cmd_t'(10'h300 + i * 10'h011), 1'b0);
    step(1'b1, 10'h0aa, 1'b1);
    total++;
    if (o_count !== 3'd3 || o_overflow !== 1'b1) begin
      bad++;
      $display("FAIL full_pushpop: got cnt=%0d ovf=%b expected cnt=3 ovf=1", o_count, o_overflow);
    end
  endtask

  task automatic test_reset_override();
    do_reset(1'b1, 10'h1e7);
    check_idle("rst_override");
    step(1'b0, '0, 1'b1);
    check_idle("rst_absent");
  endtask

  initial begin
    total = 0;
    bad = 0;
    mcnt = 0;
    movf = 1'b0;
    i_rsn = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    {i_oper, i_argA, i_argB} = '0;
    test_reset();
    test_first_push();
    test_fill_overflow();
    test_simultaneous();
    test_back_to_back();
    test_full_push_pop();
    test_reset_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
